// File: rtl/epd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// epd_pkg: shared states and constants for the Ethernet packet detector.
// Rev 1.0
// ---------------------------------------------------------------------------
package epd_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DA   = 3'd2,
        SA   = 3'd3,
        TL   = 3'd4,
        PAY  = 3'd5,
        DROP = 3'd6
    } epd_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [47:0] BCAST_MAC     = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [15:0] TYPE_MIN      = 16'h0600;
    localparam logic [15:0] LEN_MAX       = 16'd1500;
    // DA + SA + T/L bytes preceding the payload
    localparam int          HDR_BYTES     = 14;

endpackage : epd_pkg
`default_nettype wire

// File: rtl/epd_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// epd_sat_counter: W-bit up-counter that sticks at all-ones.
// Rev 1.0
// ---------------------------------------------------------------------------
module epd_sat_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule : epd_sat_counter
`default_nettype wire

// File: rtl/epd_param_detector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// epd_param_detector: per-frame Ethernet field validation and frame statistics.
// Rev 1.0
// ---------------------------------------------------------------------------
module epd_param_detector
    import epd_pkg::*;
#(
    parameter int          PRE_LEN      = 7,
    parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_01,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter int          MIN_LEN      = 64,
    parameter int          MAX_LEN      = 1518,
    parameter int          CNT_W        = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       data,
    input  logic             control,
    output logic             preamble_valid,
    output logic             dst_addr_valid,
    output logic             src_addr_valid,
    output logic             type_length_valid,
    output logic             packet_size_valid,
    output logic             frame_done,
    output logic [CNT_W-1:0] valid_packet_counter,
    output logic [CNT_W-1:0] dropped_packet_counter
);

    localparam int BC_W  = $clog2(MAX_LEN + 2);
    localparam int PRE_W = $clog2(PRE_LEN + 1);

    localparam logic [BC_W-1:0]  C_MIN_LEN = BC_W'(MIN_LEN);
    localparam logic [BC_W-1:0]  C_MAX_LEN = BC_W'(MAX_LEN);
    localparam logic [BC_W-1:0]  C_CNT_SAT = BC_W'(MAX_LEN + 1);
    localparam logic [PRE_W-1:0] C_PRE_LEN = PRE_W'(PRE_LEN);

    epd_state_e      state_q, state_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [2:0]      fld_cnt_q, fld_cnt_d;
    logic [47:0]     addr_sr_q, addr_sr_d;
    logic [15:0]     tl_q, tl_d;
    logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
    logic            armed_q, armed_d;
    logic            pre_ok_q, pre_ok_d;
    logic            dst_ok_q, dst_ok_d;
    logic            src_ok_q, src_ok_d;
    logic            tl_ok_q, tl_ok_d;
    logic            size_ok_q, size_ok_d;
    logic            done_q, done_d;
    logic            valid_inc, drop_inc;

    logic [47:0]     w_addr;
    logic [BC_W-1:0] w_cnt_inc;
    logic [31:0]     w_payload;
    logic            w_size_ok;
    logic            w_tl_ok;
    logic            w_orphan;

    assign w_addr    = {addr_sr_q[39:0], data};
    assign w_cnt_inc = (byte_cnt_q == C_CNT_SAT) ? byte_cnt_q : byte_cnt_q + 1'b1;
    assign w_payload = 32'(byte_cnt_q) - 32'(HDR_BYTES);

    // Size and T/L are only judged when the header ran to completion.
    assign w_size_ok = (state_q == PAY) &&
                       (byte_cnt_q >= C_MIN_LEN) && (byte_cnt_q <= C_MAX_LEN);

    always_comb begin
        w_tl_ok = 1'b0;
        if (state_q == PAY) begin
            if (tl_q >= TYPE_MIN) begin
                w_tl_ok = w_size_ok;
            end else if (tl_q <= LEN_MAX) begin
                w_tl_ok = (w_payload >= 32'(tl_q));
            end
        end
    end

    // A frame already in flight when reset released is swallowed silently.
    assign w_orphan = (state_q == DROP) && !armed_q;

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        fld_cnt_d  = fld_cnt_q;
        addr_sr_d  = addr_sr_q;
        tl_d       = tl_q;
        byte_cnt_d = byte_cnt_q;
        armed_d    = armed_q | ~control;
        pre_ok_d   = pre_ok_q;
        dst_ok_d   = dst_ok_q;
        src_ok_d   = src_ok_q;
        tl_ok_d    = tl_ok_q;
        size_ok_d  = size_ok_q;
        done_d     = 1'b0;
        valid_inc  = 1'b0;
        drop_inc   = 1'b0;

        if ((state_q != IDLE) && !control) begin
            state_d = IDLE;
            if (!w_orphan) begin
                done_d    = 1'b1;
                size_ok_d = w_size_ok;
                tl_ok_d   = w_tl_ok;
                if (pre_ok_q && dst_ok_q && src_ok_q && w_tl_ok && w_size_ok) begin
                    valid_inc = 1'b1;
                end else begin
                    drop_inc = 1'b1;
                end
            end
        end else if (control) begin
            case (state_q)
                IDLE: begin
                    pre_ok_d   = 1'b0;
                    dst_ok_d   = 1'b0;
                    src_ok_d   = 1'b0;
                    tl_ok_d    = 1'b0;
                    size_ok_d  = 1'b0;
                    byte_cnt_d = '0;
                    fld_cnt_d  = '0;
                    if (armed_q && (data == PREAMBLE_BYTE)) begin
                        state_d   = PRE;
                        pre_cnt_d = PRE_W'(1);
                    end else begin
                        state_d = DROP;
                    end
                end
                PRE: begin
                    if ((data == PREAMBLE_BYTE) && (pre_cnt_q < C_PRE_LEN)) begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                    end else if ((data == SFD_BYTE) && (pre_cnt_q == C_PRE_LEN)) begin
                        pre_ok_d  = 1'b1;
                        fld_cnt_d = '0;
                        state_d   = DA;
                    end else begin
                        state_d = DROP;
                    end
                end
                DA: begin
                    addr_sr_d  = w_addr;
                    byte_cnt_d = w_cnt_inc;
                    fld_cnt_d  = fld_cnt_q + 1'b1;
                    if (fld_cnt_q == 3'd5) begin
                        dst_ok_d  = (w_addr == LOCAL_MAC) ||
                                    (ACCEPT_BCAST && (w_addr == BCAST_MAC));
                        fld_cnt_d = '0;
                        state_d   = SA;
                    end
                end
                SA: begin
                    addr_sr_d  = w_addr;
                    byte_cnt_d = w_cnt_inc;
                    fld_cnt_d  = fld_cnt_q + 1'b1;
                    if (fld_cnt_q == 3'd5) begin
                        src_ok_d  = !w_addr[40] && (w_addr != 48'd0);
                        fld_cnt_d = '0;
                        state_d   = TL;
                    end
                end
                TL: begin
                    tl_d       = {tl_q[7:0], data};
                    byte_cnt_d = w_cnt_inc;
                    fld_cnt_d  = fld_cnt_q + 1'b1;
                    if (fld_cnt_q == 3'd1) begin
                        fld_cnt_d = '0;
                        state_d   = PAY;
                    end
                end
                PAY: begin
                    byte_cnt_d = w_cnt_inc;
                end
                DROP: begin
                end
                default: begin
                    state_d = DROP;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            fld_cnt_q  <= '0;
            addr_sr_q  <= '0;
            tl_q       <= '0;
            byte_cnt_q <= '0;
            armed_q    <= ~control;
            pre_ok_q   <= 1'b0;
            dst_ok_q   <= 1'b0;
            src_ok_q   <= 1'b0;
            tl_ok_q    <= 1'b0;
            size_ok_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            fld_cnt_q  <= fld_cnt_d;
            addr_sr_q  <= addr_sr_d;
            tl_q       <= tl_d;
            byte_cnt_q <= byte_cnt_d;
            armed_q    <= armed_d;
            pre_ok_q   <= pre_ok_d;
            dst_ok_q   <= dst_ok_d;
            src_ok_q   <= src_ok_d;
            tl_ok_q    <= tl_ok_d;
            size_ok_q  <= size_ok_d;
            done_q     <= done_d;
        end
    end

    assign preamble_valid    = pre_ok_q;
    assign dst_addr_valid    = dst_ok_q;
    assign src_addr_valid    = src_ok_q;
    assign type_length_valid = tl_ok_q;
    assign packet_size_valid = size_ok_q;
    assign frame_done        = done_q;

    epd_sat_counter #(.W(CNT_W)) u_valid_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (valid_inc),
        .count (valid_packet_counter)
    );

    epd_sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (drop_inc),
        .count (dropped_packet_counter)
    );

endmodule : epd_param_detector
`default_nettype wire

// File: tb/tb_epd_param_detector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_epd_param_detector: directed frames with hand-computed flag/counter values.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_epd_param_detector;

    localparam logic [47:0] C_LOCAL = 48'h02_00_00_00_00_01;
    localparam logic [47:0] C_SA    = 48'h00_11_22_33_44_55;
    localparam logic [47:0] C_BCAST = 48'hFF_FF_FF_FF_FF_FF;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data = 8'h00;
    logic       control = 1'b0;
    logic       preamble_valid, dst_addr_valid, src_addr_valid;
    logic       type_length_valid, packet_size_valid, frame_done;
    logic [3:0] valid_packet_counter, dropped_packet_counter;
    logic [5:0] flags;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    int base;

    epd_param_detector dut (
        .clock                  (clock),
        .reset                  (reset),
        .data                   (data),
        .control                (control),
        .preamble_valid         (preamble_valid),
        .dst_addr_valid         (dst_addr_valid),
        .src_addr_valid         (src_addr_valid),
        .type_length_valid      (type_length_valid),
        .packet_size_valid      (packet_size_valid),
        .frame_done             (frame_done),
        .valid_packet_counter   (valid_packet_counter),
        .dropped_packet_counter (dropped_packet_counter)
    );

    always #5 clock = ~clock;

    assign flags = {preamble_valid, dst_addr_valid, src_addr_valid,
                    type_length_valid, packet_size_valid, frame_done};

    always @(posedge clock) if (frame_done === 1'b1) done_pulses <= done_pulses + 1;

    task automatic send_byte(input logic [7:0] d);
        control = 1'b1;
        data    = d;
        @(negedge clock);
    endtask

    task automatic end_frame;
        control = 1'b0;
        data    = 8'h00;
        @(negedge clock);
    endtask

    // nbody counts every byte after the T/L field (payload plus FCS).
    task automatic send_frame(input int bad_pre, input logic [47:0] da,
                              input logic [47:0] sa, input logic [15:0] tl,
                              input int nbody);
        for (int i = 0; i < 7; i++) send_byte((i == bad_pre) ? 8'h54 : 8'h55);
        send_byte(8'hD5);
        for (int i = 0; i < 6; i++) send_byte(da[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) send_byte(sa[47-8*i -: 8]);
        send_byte(tl[15:8]);
        send_byte(tl[7:0]);
        for (int i = 0; i < nbody; i++) send_byte(8'(i + 8'h30));
        end_frame();
    endtask

    task automatic do_reset;
        reset   = 1'b1;
        control = 1'b0;
        data    = 8'h00;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (flags !== 6'b000000) begin
            errors++; $display("FAIL reset.flags: got %b want 000000", flags);
        end
        checks++;
        if (valid_packet_counter !== 4'd0 || dropped_packet_counter !== 4'd0) begin
            errors++; $display("FAIL reset.counters: got %0d/%0d want 0/0",
                               valid_packet_counter, dropped_packet_counter);
        end
    endtask

    task automatic test_good_frame;
        send_frame(-1, C_LOCAL, C_SA, 16'h0800, 50);
        checks++;
        if (flags !== 6'b111111) begin
            errors++; $display("FAIL good.flags: got %b want 111111", flags);
        end
        checks++;
        if (valid_packet_counter !== 4'd1 || dropped_packet_counter !== 4'd0) begin
            errors++; $display("FAIL good.counters: got %0d/%0d want 1/0",
                               valid_packet_counter, dropped_packet_counter);
        end
        @(negedge clock);
        checks++;
        if (flags !== 6'b111110) begin
            errors++; $display("FAIL good.hold: got %b want 111110", flags);
        end
    endtask

    task automatic test_bad_preamble;
        send_frame(5, C_LOCAL, C_SA, 16'h0800, 50);
        checks++;
        if (flags !== 6'b000001) begin
            errors++; $display("FAIL badpre.flags: got %b want 000001", flags);
        end
        checks++;
        if (valid_packet_counter !== 4'd1 || dropped_packet_counter !== 4'd1) begin
            errors++; $display("FAIL badpre.counters: got %0d/%0d want 1/1",
                               valid_packet_counter, dropped_packet_counter);
        end
    endtask

    task automatic test_addresses;
        send_frame(-1, C_BCAST, C_SA, 16'h0800, 50);
        checks++;
        if (flags !== 6'b111111 || valid_packet_counter !== 4'd2) begin
            errors++; $display("FAIL bcast: got %b cnt %0d want 111111 cnt 2",
                               flags, valid_packet_counter);
        end
        send_frame(-1, 48'd0, C_SA, 16'h0800, 50);
        checks++;
        if (flags !== 6'b101111 || dropped_packet_counter !== 4'd2) begin
            errors++; $display("FAIL da_zero: got %b cnt %0d want 101111 cnt 2",
                               flags, dropped_packet_counter);
        end
        send_frame(-1, C_LOCAL, 48'h01_11_22_33_44_55, 16'h0800, 50);
        checks++;
        if (flags !== 6'b110111 || dropped_packet_counter !== 4'd3) begin
            errors++; $display("FAIL sa_mcast: got %b cnt %0d want 110111 cnt 3",
                               flags, dropped_packet_counter);
        end
    endtask

    task automatic test_type_length;
        send_frame(-1, C_LOCAL, C_SA, 16'h0010, 50);
        checks++;
        if (flags !== 6'b111111 || valid_packet_counter !== 4'd3) begin
            errors++; $display("FAIL len16: got %b cnt %0d want 111111 cnt 3",
                               flags, valid_packet_counter);
        end
        send_frame(-1, C_LOCAL, C_SA, 16'h002E, 34);
        checks++;
        if (flags !== 6'b111001 || dropped_packet_counter !== 4'd4) begin
            errors++; $display("FAIL short48: got %b cnt %0d want 111001 cnt 4",
                               flags, dropped_packet_counter);
        end
        send_frame(-1, C_LOCAL, C_SA, 16'h05F0, 50);
        checks++;
        if (flags !== 6'b111011 || dropped_packet_counter !== 4'd5) begin
            errors++; $display("FAIL tl_gap: got %b cnt %0d want 111011 cnt 5",
                               flags, dropped_packet_counter);
        end
    endtask

    task automatic test_truncated;
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
        for (int i = 0; i < 6; i++) send_byte(C_LOCAL[47-8*i -: 8]);
        for (int i = 0; i < 3; i++) send_byte(C_SA[47-8*i -: 8]);
        end_frame();
        checks++;
        if (flags !== 6'b110001 || dropped_packet_counter !== 4'd6) begin
            errors++; $display("FAIL trunc: got %b cnt %0d want 110001 cnt 6",
                               flags, dropped_packet_counter);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        base = done_pulses;
        for (int n = 0; n < 17; n++) begin
            send_frame(-1, C_LOCAL, C_SA, 16'h0800, 50);
            if (n == 14) begin
                checks++;
                if (valid_packet_counter !== 4'd15) begin
                    errors++; $display("FAIL b2b.at15: got %0d want 15", valid_packet_counter);
                end
            end
        end
        checks++;
        if (valid_packet_counter !== 4'd15 || dropped_packet_counter !== 4'd0) begin
            errors++; $display("FAIL b2b.sat: got %0d/%0d want 15/0",
                               valid_packet_counter, dropped_packet_counter);
        end
        @(negedge clock);
        checks++;
        if (done_pulses - base !== 17) begin
            errors++; $display("FAIL b2b.pulses: got %0d want 17", done_pulses - base);
        end
    endtask

    task automatic test_reset_mid_frame;
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
        for (int i = 0; i < 6; i++) send_byte(C_LOCAL[47-8*i -: 8]);
        for (int i = 0; i < 2; i++) send_byte(C_SA[47-8*i -: 8]);
        reset = 1'b1;
        send_byte(8'h55);
        checks++;
        if (flags !== 6'b000000 || valid_packet_counter !== 4'd0 ||
            dropped_packet_counter !== 4'd0) begin
            errors++; $display("FAIL rstmid.zero: got %b %0d/%0d want 000000 0/0",
                               flags, valid_packet_counter, dropped_packet_counter);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) send_byte((i == 7) ? 8'hD5 : 8'h55);
        end_frame();
        checks++;
        if (flags !== 6'b000000 || valid_packet_counter !== 4'd0 ||
            dropped_packet_counter !== 4'd0) begin
            errors++; $display("FAIL rstmid.drop: got %b %0d/%0d want 000000 0/0",
                               flags, valid_packet_counter, dropped_packet_counter);
        end
        send_frame(-1, C_LOCAL, C_SA, 16'h0800, 50);
        checks++;
        if (flags !== 6'b111111 || valid_packet_counter !== 4'd1 ||
            dropped_packet_counter !== 4'd0) begin
            errors++; $display("FAIL rstmid.next: got %b %0d/%0d want 111111 1/0",
                               flags, valid_packet_counter, dropped_packet_counter);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_preamble();
        test_addresses();
        test_type_length();
        test_truncated();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_epd_param_detector
`default_nettype wire
